pc_fetch_stage: RTL and testbench
=================================

// Module: pc_fetch_stage
// PURPOSE
//  IF stage: owns the PC register, consumes next-PC select and branch/jump targets from ID, fetches over a
//  req/ready instruction-memory port, loads the IF/ID pipeline register. Handles hazard-unit stall, redirect flush
//  and memory wait states; at most one fetch in flight; zero-wait memory sustains one instruction per cycle.
// PARAMETERS
//  DATABIT   32            data/address width
//  RESET_PC  32'h0000_3000 PC value after reset
//  NOP_INSTR 32'h0000_0000 instruction written into IF/ID on reset/flush
// PORTS
//  Clk          in  1        clock, all state updates on rising edge
//  Reset_n      in  1        asynchronous, active-low reset
//  PCSel        in  3        0 seq, 1 beq, 2 j/jal, 3 jr/jalr, 4 bne; 5-7 = seq
//  BeqTarget    in  DATABIT  beq target
//  JTarget      in  DATABIT  j/jal target
//  JrTarget     in  DATABIT  jr/jalr register target
//  BneTarget    in  DATABIT  bne target
//  Stall        in  1        hazard unit: hold IF/ID
//  IMemReq      out 1        fetch request
//  IMemAddr     out DATABIT  fetch address, stable while IMemReq && !IMemReady
//  IMemReady    in  1        fetch done this cycle; IMemRData valid
//  IMemRData    in  DATABIT  fetched instruction
//  PC           out DATABIT  current PC register
//  IfIdInstr    out DATABIT  IF/ID instruction
//  IfIdPCPlus4  out DATABIT  IF/ID PC+4 of that instruction
//  IfIdValid    out 1        IF/ID holds a real instruction
//  AlignErr     out 1        1-cycle pulse: redirect target had [1:0]!=0 (low bits forced to 00)
// BEHAVIOUR
//  Reset (async, Reset_n=0): PC=RESET_PC, state=S_BOOT, IMemReq=0, IfIdValid=0, IfIdInstr=NOP_INSTR,
//   IfIdPCPlus4=0, AlignErr=0, skid invalid, DropAddr=0. Reset mid-fetch abandons it; no handshake completion.
//  Redirect = (PCSel in 1..4) in S_REQ/S_DROP/S_HOLD; ignored in S_BOOT. Target via 5:1 select on PCSel, [1:0]
//   masked to 00. Redirect: PC<=target, IF/ID flushed (Valid=0, Instr=NOP_INSTR), skid invalidated.
//  Priority: reset > redirect > stall > normal. Flush beats Stall.
//  Fetch accepted = IMemReq && IMemReady at a rising edge; accepted non-dropped fetch always does PC<=PC+4.
//  FSM:
//   S_BOOT: IMemReq=0; next cycle -> S_REQ.
//   S_REQ : IMemReq=1, IMemAddr=PC.
//     redirect && !ready -> S_DROP, DropAddr<=PC.   redirect && ready -> S_REQ, data discarded.
//     ready && !Stall -> IF/ID<={data,PC+4,1}, S_REQ.   ready && Stall -> skid<={data,PC+4}, S_HOLD.
//     !ready -> stay; IF/ID unchanged.
//   S_DROP: IMemReq=1, IMemAddr=DropAddr (old request held stable). ready -> S_REQ, data discarded.
//     Further redirects update PC only (newest target wins), stay.
//   S_HOLD: IMemReq=0. redirect -> S_REQ. !Stall -> IF/ID<=skid, Valid=1, S_REQ. Stall -> stay.
//  Stall with no ready: IF/ID held; the outstanding request stays asserted.
//  IF/ID: !Stall && no load -> IfIdValid<=0 (bubble). Stall -> all IF/ID regs hold.
//  Arithmetic: PC+4 mod 2^DATABIT; 32'hFFFF_FFFC wraps to 0, no flag.
//  Latency: IMemReady at edge N -> IfIdInstr valid after N. Redirect at edge N -> new PC on IMemAddr after N
//   (S_REQ) or one cycle after the drop completes (S_DROP).
// STRUCTURE
//  Shared package cpu_pkg: PCSel encodings (PCSEL_SEQ/BEQ/J/JR/BNE), fetch FSM state enum, NOP_INSTR.
//  Sub-module: MUX5to1 (DATABIT) selects the redirect target. The rest is flat: FSM, PC register, skid, IF/ID.
// TESTING
//  1 Reset then zero-wait memory (IMemReady=1) -> IMemAddr 3000,3004,3008 on consecutive cycles, IfIdValid=1 from 3rd edge.
//  2 Ready held low 3 cycles at PC=3004 -> IMemAddr stays 3004, IfIdValid=0 bubbles, then instr at PC+4=3008.
//  3 Ready && Stall at PC=3008 -> S_HOLD, IMemReq=0, IF/ID unchanged; Stall drops -> IfIdInstr=skid data, next addr 300C.
//  4 PCSel=1, BeqTarget=3100, ready=0 -> IMemAddr holds old addr until ready, data dropped, then 3100; IfIdValid=0.
//  5 PCSel=3, JrTarget=3102 with Stall=1 in S_HOLD -> flush wins, skid cleared, AlignErr pulses, next fetch 3100.
//  6 Reset_n low mid-request and mid-stall -> all outputs return to reset values asynchronously; PC=3000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: next-PC select encodings, fetch FSM states and the NOP encoding.
package cpu_pkg;

  typedef enum logic [2:0] {
    PCSEL_SEQ = 3'd0,
    PCSEL_BEQ = 3'd1,
    PCSEL_J   = 3'd2,
    PCSEL_JR  = 3'd3,
    PCSEL_BNE = 3'd4
  } pcsel_e;

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_DROP,
    S_HOLD
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/MUX5to1.sv
// Five-way next-PC target selector; encodings 5-7 fall back to the sequential input.
module MUX5to1 #(
  parameter int DATABIT = 32
) (
  input  logic [2:0]         sel,
  input  logic [DATABIT-1:0] d0,
  input  logic [DATABIT-1:0] d1,
  input  logic [DATABIT-1:0] d2,
  input  logic [DATABIT-1:0] d3,
  input  logic [DATABIT-1:0] d4,
  output logic [DATABIT-1:0] y
);
  import cpu_pkg::*;

  always_comb begin
    y = d0;
    case (sel)
      PCSEL_BEQ: y = d1;
      PCSEL_J:   y = d2;
      PCSEL_JR:  y = d3;
      PCSEL_BNE: y = d4;
      default:   y = d0;
    endcase
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// IF stage: PC register, single-outstanding req/ready fetch, skid buffer for stalls and the IF/ID register.
module pc_fetch_stage #(
  parameter int                   DATABIT   = 32,
  parameter logic [DATABIT-1:0]   RESET_PC  = 32'h0000_3000,
  parameter logic [DATABIT-1:0]   NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [2:0]         PCSel,
  input  logic [DATABIT-1:0] BeqTarget,
  input  logic [DATABIT-1:0] JTarget,
  input  logic [DATABIT-1:0] JrTarget,
  input  logic [DATABIT-1:0] BneTarget,
  input  logic               Stall,
  output logic               IMemReq,
  output logic [DATABIT-1:0] IMemAddr,
  input  logic               IMemReady,
  input  logic [DATABIT-1:0] IMemRData,
  output logic [DATABIT-1:0] PC,
  output logic [DATABIT-1:0] IfIdInstr,
  output logic [DATABIT-1:0] IfIdPCPlus4,
  output logic               IfIdValid,
  output logic               AlignErr
);
  import cpu_pkg::*;

  fetch_state_e       state, state_next;
  logic [DATABIT-1:0] pc, pc_plus4, drop_addr;
  logic [DATABIT-1:0] raw_target, target;
  logic [DATABIT-1:0] skid_instr, skid_pc4;
  logic               skid_vld;
  logic [DATABIT-1:0] ifid_instr, ifid_pc4;
  logic               ifid_valid, align_err;
  logic               redirect, sel_redirect;
  logic               pc_tgt, pc_inc, drop_load, skid_load;
  logic               flush, load_mem, load_skid, bubble;

  assign pc_plus4     = pc + DATABIT'(4);
  assign sel_redirect = (PCSel >= 3'(PCSEL_BEQ)) && (PCSel <= 3'(PCSEL_BNE));
  assign redirect     = sel_redirect && (state != S_BOOT);

  MUX5to1 #(.DATABIT(DATABIT)) u_target_mux (
    .sel (PCSel),
    .d0  (pc_plus4),
    .d1  (BeqTarget),
    .d2  (JTarget),
    .d3  (JrTarget),
    .d4  (BneTarget),
    .y   (raw_target)
  );

  assign target = {raw_target[DATABIT-1:2], 2'b00};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_BOOT;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    IMemReq    = 1'b0;
    pc_tgt     = 1'b0;
    pc_inc     = 1'b0;
    drop_load  = 1'b0;
    skid_load  = 1'b0;
    flush      = 1'b0;
    load_mem   = 1'b0;
    load_skid  = 1'b0;
    bubble     = 1'b0;
    case (state)
      S_BOOT: begin
        state_next = S_REQ;
        bubble     = !Stall;
      end
      S_REQ: begin
        IMemReq = 1'b1;
        if (redirect) begin
          pc_tgt = 1'b1;
          flush  = 1'b1;
          // A request the memory has not yet answered must be held until it completes.
          if (!IMemReady) begin
            state_next = S_DROP;
            drop_load  = 1'b1;
          end
        end else if (IMemReady) begin
          pc_inc = 1'b1;
          if (!Stall) begin
            load_mem = 1'b1;
          end else begin
            skid_load  = 1'b1;
            state_next = S_HOLD;
          end
        end else begin
          bubble = !Stall;
        end
      end
      S_DROP: begin
        IMemReq = 1'b1;
        if (redirect) begin
          pc_tgt = 1'b1;
          flush  = 1'b1;
        end else begin
          bubble = !Stall;
        end
        if (IMemReady) state_next = S_REQ;
      end
      S_HOLD: begin
        if (redirect) begin
          pc_tgt     = 1'b1;
          flush      = 1'b1;
          state_next = S_REQ;
        end else if (!Stall) begin
          load_skid  = 1'b1;
          state_next = S_REQ;
        end
      end
      default: state_next = S_BOOT;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc         <= RESET_PC;
      drop_addr  <= '0;
      skid_instr <= NOP_INSTR;
      skid_pc4   <= '0;
      skid_vld   <= 1'b0;
      ifid_instr <= NOP_INSTR;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      if (pc_tgt)      pc <= target;
      else if (pc_inc) pc <= pc_plus4;
      if (drop_load) drop_addr <= pc;
      if (flush) begin
        skid_vld <= 1'b0;
      end else if (skid_load) begin
        skid_instr <= IMemRData;
        skid_pc4   <= pc_plus4;
        skid_vld   <= 1'b1;
      end
      if (flush) begin
        ifid_instr <= NOP_INSTR;
        ifid_valid <= 1'b0;
      end else if (load_mem) begin
        ifid_instr <= IMemRData;
        ifid_pc4   <= pc_plus4;
        ifid_valid <= 1'b1;
      end else if (load_skid) begin
        ifid_instr <= skid_instr;
        ifid_pc4   <= skid_pc4;
        ifid_valid <= skid_vld;
      end else if (bubble) begin
        ifid_valid <= 1'b0;
      end
      align_err <= pc_tgt && (raw_target[1:0] != 2'b00);
    end
  end

  assign IMemAddr    = (state == S_DROP) ? drop_addr : pc;
  assign PC          = pc;
  assign IfIdInstr   = ifid_instr;
  assign IfIdPCPlus4 = ifid_pc4;
  assign IfIdValid   = ifid_valid;
  assign AlignErr    = align_err;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage; instruction memory returns address ^ 32'hDEAD_0000.
module tb_pc_fetch_stage;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [2:0]  PCSel;
  logic [31:0] BeqTarget, JTarget, JrTarget, BneTarget;
  logic        Stall;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemRData;
  logic [31:0] PC, IfIdInstr, IfIdPCPlus4;
  logic        IfIdValid, AlignErr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  assign IMemRData = IMemAddr ^ 32'hDEAD_0000;

  pc_fetch_stage #(
    .DATABIT   (32),
    .RESET_PC  (32'h0000_3000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .PCSel       (PCSel),
    .BeqTarget   (BeqTarget),
    .JTarget     (JTarget),
    .JrTarget    (JrTarget),
    .BneTarget   (BneTarget),
    .Stall       (Stall),
    .IMemReq     (IMemReq),
    .IMemAddr    (IMemAddr),
    .IMemReady   (IMemReady),
    .IMemRData   (IMemRData),
    .PC          (PC),
    .IfIdInstr   (IfIdInstr),
    .IfIdPCPlus4 (IfIdPCPlus4),
    .IfIdValid   (IfIdValid),
    .AlignErr    (AlignErr)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk_eq({tag, "_pc"},    PC,          32'h0000_3000);
    chk_eq({tag, "_req"},   {31'd0, IMemReq},   32'd0);
    chk_eq({tag, "_valid"}, {31'd0, IfIdValid}, 32'd0);
    chk_eq({tag, "_instr"}, IfIdInstr,   32'h0000_0000);
    chk_eq({tag, "_pc4"},   IfIdPCPlus4, 32'h0000_0000);
    chk_eq({tag, "_align"}, {31'd0, AlignErr},  32'd0);
  endtask

  initial begin
    Reset_n   = 1'b0;
    PCSel     = 3'd0;
    BeqTarget = 32'h0;
    JTarget   = 32'h0;
    JrTarget  = 32'h0;
    BneTarget = 32'h0;
    Stall     = 1'b0;
    IMemReady = 1'b0;
    #12;
    chk_reset("rst");

    // Zero-wait sequential fetch
    step();
    Reset_n   = 1'b1;
    IMemReady = 1'b1;
    chk_eq("boot_req", {31'd0, IMemReq}, 32'd0);
    step();
    chk_eq("t1_addr0", IMemAddr, 32'h0000_3000);
    chk_eq("t1_req0",  {31'd0, IMemReq}, 32'd1);
    step();
    chk_eq("t1_addr1",  IMemAddr,  32'h0000_3004);
    chk_eq("t1_valid1", {31'd0, IfIdValid}, 32'd1);
    chk_eq("t1_instr1", IfIdInstr, 32'hDEAD_3000);
    chk_eq("t1_pc4_1",  IfIdPCPlus4, 32'h0000_3004);

    // Memory wait states at 3004
    IMemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_eq("t2_addr_wait",  IMemAddr, 32'h0000_3004);
      chk_eq("t2_valid_wait", {31'd0, IfIdValid}, 32'd0);
    end
    IMemReady = 1'b1;
    step();
    chk_eq("t2_instr", IfIdInstr,   32'hDEAD_3004);
    chk_eq("t2_pc4",   IfIdPCPlus4, 32'h0000_3008);
    chk_eq("t2_valid", {31'd0, IfIdValid}, 32'd1);
    chk_eq("t1_addr2", IMemAddr,    32'h0000_3008);

    // Ready together with Stall parks data in the skid
    Stall = 1'b1;
    step();
    chk_eq("t3_req",   {31'd0, IMemReq}, 32'd0);
    chk_eq("t3_instr", IfIdInstr, 32'hDEAD_3004);
    chk_eq("t3_valid", {31'd0, IfIdValid}, 32'd1);
    chk_eq("t3_pc",    PC, 32'h0000_300C);
    step();
    chk_eq("t3_req_hold", {31'd0, IMemReq}, 32'd0);
    chk_eq("t3_instr_hold", IfIdInstr, 32'hDEAD_3004);
    Stall = 1'b0;
    step();
    chk_eq("t3_skid_instr", IfIdInstr,   32'hDEAD_3008);
    chk_eq("t3_skid_pc4",   IfIdPCPlus4, 32'h0000_300C);
    chk_eq("t3_skid_valid", {31'd0, IfIdValid}, 32'd1);
    chk_eq("t3_next_addr",  IMemAddr,    32'h0000_300C);

    // Branch redirect while a fetch is outstanding
    IMemReady = 1'b0;
    PCSel     = 3'd1;
    BeqTarget = 32'h0000_3100;
    step();
    PCSel = 3'd0;
    chk_eq("t4_addr_old", IMemAddr, 32'h0000_300C);
    chk_eq("t4_pc",       PC,       32'h0000_3100);
    chk_eq("t4_valid",    {31'd0, IfIdValid}, 32'd0);
    chk_eq("t4_nop",      IfIdInstr, 32'h0000_0000);
    step();
    chk_eq("t4_addr_old2", IMemAddr, 32'h0000_300C);
    chk_eq("t4_req_drop",  {31'd0, IMemReq}, 32'd1);
    IMemReady = 1'b1;
    step();
    chk_eq("t4_addr_new", IMemAddr, 32'h0000_3100);
    chk_eq("t4_valid2",   {31'd0, IfIdValid}, 32'd0);
    chk_eq("t4_pc_nodrop", PC, 32'h0000_3100);

    // Misaligned jr while stalled in the skid state: flush wins
    Stall = 1'b1;
    step();
    chk_eq("t5_req_hold", {31'd0, IMemReq}, 32'd0);
    chk_eq("t5_pc_hold",  PC, 32'h0000_3104);
    PCSel    = 3'd3;
    JrTarget = 32'h0000_3102;
    step();
    chk_eq("t5_align", {31'd0, AlignErr}, 32'd1);
    chk_eq("t5_valid", {31'd0, IfIdValid}, 32'd0);
    chk_eq("t5_pc",    PC, 32'h0000_3100);
    chk_eq("t5_addr",  IMemAddr, 32'h0000_3100);
    chk_eq("t5_req",   {31'd0, IMemReq}, 32'd1);
    PCSel = 3'd0;
    Stall = 1'b0;
    step();
    chk_eq("t5_align_pulse", {31'd0, AlignErr}, 32'd0);
    chk_eq("t5_instr", IfIdInstr,   32'hDEAD_3100);
    chk_eq("t5_pc4",   IfIdPCPlus4, 32'h0000_3104);

    // Jump with ready discards data; PC+4 wraps at the top of the address space
    PCSel   = 3'd2;
    JTarget = 32'hFFFF_FFFC;
    step();
    PCSel = 3'd0;
    chk_eq("wrap_addr",  IMemAddr, 32'hFFFF_FFFC);
    chk_eq("wrap_flush", {31'd0, IfIdValid}, 32'd0);
    step();
    chk_eq("wrap_pc",    PC, 32'h0000_0000);
    chk_eq("wrap_instr", IfIdInstr, 32'h2152_FFFC);
    chk_eq("wrap_pc4",   IfIdPCPlus4, 32'h0000_0000);
    chk_eq("wrap_valid", {31'd0, IfIdValid}, 32'd1);

    // bne redirect, then an unused select code behaving as sequential
    PCSel     = 3'd4;
    BneTarget = 32'h0000_3200;
    step();
    chk_eq("bne_pc",    PC, 32'h0000_3200);
    chk_eq("bne_valid", {31'd0, IfIdValid}, 32'd0);
    PCSel = 3'd5;
    step();
    PCSel = 3'd0;
    chk_eq("sel5_pc",    PC, 32'h0000_3204);
    chk_eq("sel5_instr", IfIdInstr, 32'hDEAD_3200);

    // Asynchronous reset mid-request
    IMemReady = 1'b0;
    step();
    #2;
    Reset_n = 1'b0;
    #1;
    chk_reset("rst_req");
    step();
    Reset_n = 1'b1;
    step();
    IMemReady = 1'b1;
    Stall     = 1'b1;
    step();
    chk_eq("pre_rst_hold_req", {31'd0, IMemReq}, 32'd0);
    #2;
    Reset_n = 1'b0;
    #1;
    chk_reset("rst_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
